// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the 101010 detector: takes WIDTH-bit words over valid/ready
// and emits one registered bit per clock, with a one-word holding register for gapless streaming.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             state_dbg
);

  // Handshake: a word moves on every rising edge where din_valid and din_ready are both 1.
  // din_ready depends only on the registered hold_full flag; the producer may drop din_valid
  // at any time without a transfer.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             hold_full_q, hold_full_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             x_q, x_n;
  logic             bv_q, bv_n;
  logic             lb_q, lb_n;
  logic             load_en;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shifted;
  logic             transfer;
  logic             end_word;

  assign transfer = din_valid & ~hold_full_q;
  assign end_word = (state_q == SHIFT) && (cnt_q == LAST);
  assign shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_n     = state_q;
    sh_n        = sh_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    cnt_n       = cnt_q;
    load_en     = 1'b0;
    load_word   = din;
    case (state_q)
      IDLE: begin
        if (transfer) load_en = 1'b1;
      end
      SHIFT: begin
        if (end_word) begin
          // Held word wins over a fresh transfer; din_ready is 0 then, so both cannot occur.
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_n = 1'b0;
          end else if (transfer) begin
            load_en = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          sh_n  = shifted;
          cnt_n = cnt_q + 1'b1;
          if (transfer) begin
            hold_n      = din;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load_en) begin
      sh_n    = load_word;
      cnt_n   = '0;
      state_n = SHIFT;
    end
    // Outputs are registered copies of what the next state will present.
    x_n  = (state_n == SHIFT) ? (MSB_FIRST ? sh_n[WIDTH-1] : sh_n[0]) : IDLE_BIT;
    bv_n = (state_n == SHIFT);
    lb_n = (state_n == SHIFT) && (cnt_n == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      x_q         <= IDLE_BIT;
      bv_q        <= 1'b0;
      lb_q        <= 1'b0;
    end else begin
      state_q     <= state_n;
      sh_q        <= sh_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      cnt_q       <= cnt_n;
      x_q         <= x_n;
      bv_q        <= bv_n;
      lb_q        <= lb_n;
    end
  end

  assign din_ready = ~hold_full_q;
  assign x_out     = x_q;
  assign bit_valid = bv_q;
  assign last_bit  = lb_q;
  assign busy      = (state_q == SHIFT) | hold_full_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: two instances (MSB-first/idle 0 and LSB-first/idle 1) share
// stimulus; a bit-queue model predicts every output each cycle, plus literal spot checks.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_a, x_a, bv_a, lb_a, busy_a, st_a;
  logic rdy_b, x_b, bv_b, lb_b, busy_b, st_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 0;

  // Each entry is {bit, last}; front entry is what x_out shows in the current cycle.
  logic [1:0] exp_q[$];
  logic [1:0] exp2_q[$];
  int acc_q[$];

  always #5 clock = ~clock;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .x_out(x_a), .bit_valid(bv_a), .last_bit(lb_a), .busy(busy_a), .state_dbg(st_a));

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .x_out(x_b), .bit_valid(bv_b), .last_bit(lb_b), .busy(busy_b), .state_dbg(st_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Model: pop the shown bit each edge, append a word's bits on acceptance.
  always @(posedge clock) begin
    bit xfer;
    if (reset) begin
      exp_q.delete();
      exp2_q.delete();
      armed = 1;
    end else begin
      xfer = din_valid && (exp_q.size() <= W);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp2_q.pop_front());
      end
      if (xfer) begin
        acc_q.push_back(cyc);
        for (int i = 0; i < W; i++) begin
          exp_q.push_back({din[W-1-i], i == W - 1});
          exp2_q.push_back({din[i], i == W - 1});
        end
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (armed) begin
      bit any;
      any = exp_q.size() > 0;
      chk("x_a", x_a, any ? exp_q[0][1] : 1'b0);
      chk("bv_a", bv_a, any);
      chk("lb_a", lb_a, any ? exp_q[0][0] : 1'b0);
      chk("busy_a", busy_a, any);
      chk("rdy_a", rdy_a, exp_q.size() <= W);
      chk("x_b", x_b, any ? exp2_q[0][1] : 1'b1);
      chk("bv_b", bv_b, any);
      chk("lb_b", lb_b, any ? exp2_q[0][0] : 1'b0);
      chk("busy_b", busy_b, any);
      chk("rdy_b", rdy_b, exp_q.size() <= W);
    end
  end

  task automatic send(input logic [W-1:0] w);
    int t;
    t = 0;
    @(negedge clock);
    din = w;
    din_valid = 1'b1;
    while (!rdy_a && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (!rdy_a) timeout("send_ready");
    @(posedge clock);
    #1 din_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [23:0] v, output logic [23:0] v2);
    int t;
    t = 0;
    v = '0;
    v2 = '0;
    @(negedge clock);
    while (!bv_a && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!bv_a) timeout("capture_start");
    for (int i = 0; i < n; i++) begin
      v = {v[22:0], x_a};
      v2 = {v2[22:0], x_b};
      if (i < n - 1) @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clock);
    while (busy_a && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (busy_a) timeout("wait_idle");
  endtask

  initial begin
    logic [23:0] va, vb;
    int ones, zeros, t;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] va, vb;
    int ones, zeros, t;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_rdy", rdy_a, 1'b1);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_x_b", x_b, 1'b1);

    // Single word, MSB first: 0x2A -> 0,0,1,0,1,0,1,0
    fork
      send(8'h2A);
      capture(8, va, vb);
    join
    chk("t1_bits_a", va[7:0], 8'h2A);
    chk("t1_bits_b", vb[7:0], 8'h54);
    @(negedge clock);
    chk("t1_after_bv", bv_a, 1'b0);
    chk("t1_after_x", x_a, 1'b0);
    chk("t1_after_busy", busy_a, 1'b0);

    // Back-to-back words
    wait_idle();
    fork
      begin send(8'hA5); send(8'h3C); end
      capture(16, va, vb);
    join
    chk("t2_bits_a", va[15:0], 16'hA53C);
    chk("t2_bits_b", vb[15:0], 16'hA53C);

    // Saturation with four words queued by a persistent producer
    wait_idle();
    acc_q.delete();
    fork
      begin send(8'h12); send(8'h34); send(8'h56); send(8'h78); end
      capture(24, va, vb);
    join
    chk("t3_bits_a", va, 24'h123456);
    chk("t3_bits_b", vb, 24'h482C6A);
    if (acc_q.size() == 4) begin
      chk("t3_acc_b", acc_q[1] - acc_q[0], 1);
      chk("t3_acc_c", acc_q[2] - acc_q[0], 9);
      chk("t3_acc_d", acc_q[3] - acc_q[0], 17);
    end else begin
      chk("t3_acc_count", acc_q.size(), 4);
    end

    // Bit order: 0x01
    wait_idle();
    fork
      send(8'h01);
      capture(8, va, vb);
    join
    chk("t4_bits_a", va[7:0], 8'h01);
    chk("t4_bits_b", vb[7:0], 8'h80);
    chk("t4_last_a", lb_a, 1'b1);
    chk("t4_last_b", lb_b, 1'b1);

    // Reset mid-word with a held word pending
    wait_idle();
    send(8'hFF);
    send(8'h55);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("t5_bv", bv_a, 1'b0);
    chk("t5_busy", busy_a, 1'b0);
    chk("t5_rdy", rdy_a, 1'b1);
    chk("t5_x_b", x_b, 1'b1);

    // Idle fill for 20 cycles
    ones = 0;
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (x_b === 1'b1 && bv_b === 1'b0 && lb_b === 1'b0) ones++;
      if (x_a === 1'b0 && bv_a === 1'b0) zeros++;
    end
    chk("t6_idle_b", ones, 20);
    chk("t6_idle_a", zeros, 20);

    // Transfer exactly at the end-of-word edge with hold empty
    send(8'hC3);
    t = 0;
    @(negedge clock);
    while (!lb_a && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (!lb_a) timeout("t6_last");
    din = 8'h96;
    din_valid = 1'b1;
    @(posedge clock);
    #1 din_valid = 1'b0;
    @(negedge clock);
    chk("t6_gapless_bv", bv_a, 1'b1);
    chk("t6_gapless_x", x_a, 1'b1);
    wait_idle();
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-to-serial stage directly upstream of the 101010 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and drives one registered bit per clock onto the detector's serial `x` input.
- A one-word holding register lets back-to-back words stream with no idle gap.
- When no word is in flight, the serial line sits at a fixed idle level, so the detector sees a defined bit every cycle.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_BIT, 0, level driven on x_out whenever no word is shifting.

Ports:
- clock  input  1  rising-edge clock, shared with the detector
- reset  input  1  synchronous, active-high
- din  input  WIDTH  parallel word; sampled on a transfer edge
- din_valid  input  1  producer has a word on din
- din_ready  output  1  block can take a word this cycle
- x_out  output  1  serial bit, registered; connects to detector x
- bit_valid  output  1  x_out carries a word bit (not idle fill)
- last_bit  output  1  x_out is the final bit of the current word
- busy  output  1  shifter active or holding register full

Behaviour:
- Clocking: all state updates on rising clock. Synchronous active-high reset, single clock.
- Reset values:
  - x_out = IDLE_BIT; bit_valid = 0; last_bit = 0; busy = 0; din_ready = 1.
  - Shifter and holding register empty; bit counter = 0.
  - Reset has priority over everything at the same edge.
- Transfer: occurs at an edge where din_valid and din_ready are both 1.
- din_ready = NOT hold_full, decoded from a registered flag only. No combinational path from din_valid or from shifter state.
- Storage: shift register (WIDTH), holding register (WIDTH) + hold_full flag, bit counter (clog2(WIDTH) bits), state IDLE/SHIFT.
- IDLE:
  - x_out = IDLE_BIT, bit_valid = 0.
  - A transfer at edge N loads din straight into the shifter.
  - First bit is on x_out and bit_valid = 1 in the cycle after edge N (latency 1).
  - State -> SHIFT, counter = 0.
- SHIFT:
  - Each edge advances one bit and increments the counter.
  - last_bit = 1 while counter = WIDTH-1.
  - Bit order follows MSB_FIRST.
- End of word (the edge terminating the last_bit cycle), priority order:
  1. hold_full: the holding word moves to the shifter; its first bit appears next cycle with no gap; hold_full clears.
  2. A transfer at this same edge with hold empty: din loads directly into the shifter, again with no gap.
  3. Otherwise: state -> IDLE; x_out = IDLE_BIT; bit_valid = 0.
- Transfer during SHIFT that is not at the end-of-word edge: din -> holding register; hold_full sets, so din_ready = 0 from the next cycle.
- Hold handover at the end-of-word edge: din_ready stays 0 for the cycle containing that edge and returns to 1 the following cycle. No transfer into the hold register can coincide with its own drain.
- No underrun or overrun is possible: din is never overwritten while hold_full = 1.
- busy = (state == SHIFT) OR hold_full.
- Reset mid-word: the current word and any held word are discarded. The next cycle shows the reset values; no partial bits are emitted afterwards.
- din_valid dropped without a transfer: no effect. The producer may withdraw freely; no valid-stability requirement is enforced.
- With WIDTH=8, MSB_FIRST=1, input 0x2A produces 0,0,1,0,1,0,1,0. The detector output z goes high on the final 0, provided the prior idle fill did not pre-load a partial match.

Test Plan:
1. Single word, WIDTH=8, MSB_FIRST=1: reset, then transfer 0x2A at edge 0 -> x_out = 0,0,1,0,1,0,1,0 in cycles 1..8; bit_valid = 1 in cycles 1..8; last_bit only in cycle 8; cycle 9 x_out = 0, bit_valid = 0, busy = 0; detector z = 1 after bit 8.
2. Back-to-back: transfer 0xA5 at edge 0 and 0x3C at edge 1 -> 16 contiguous valid bits 10100101 00111100; din_ready = 0 in cycles 2..8 and 1 in cycle 9; no bit_valid gap.
3. Saturation: din_valid held at 1 with words A, B, C -> A at edge 0, B at edge 1, C at edge 9, next accept at edge 17; bit_valid is never 0 across the 24 bits; no word lost or duplicated.
4. LSB-first (MSB_FIRST=0): transfer 0x01 -> x_out = 1,0,0,0,0,0,0,0; last_bit with the 8th bit.
5. Reset mid-word: transfer 0xFF and a held 0x55, assert reset during bit 3 -> next cycle x_out = IDLE_BIT, bit_valid = 0, busy = 0, din_ready = 1; after release, no stale bits appear.
6. Idle and IDLE_BIT=1: no transfers for 20 cycles -> x_out constant 1, bit_valid = 0, last_bit = 0; a transfer at the end-of-word edge with hold empty (case 2 above) still gives gapless output.
